// File: rtl/step_sequencer.sv
// Four-row, sixteen-step pattern sequencer with a tempo divider and play/pause/stop control.
// Patterns are edited live through a row cursor; step entry raises registered note pulses.
module step_sequencer #(
    parameter int BASE_TICKS = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        stop,
    input  logic        rowUp,
    input  logic        rowDown,
    input  logic        toggle,
    input  logic        clear,
    input  logic [3:0]  colIn,
    input  logic [1:0]  tempoSel,
    output logic [15:0] qOut1,
    output logic [15:0] qOut2,
    output logic [15:0] qOut3,
    output logic [15:0] qOut4,
    output logic [3:0]  beat,
    output logic [1:0]  select,
    output logic [3:0]  noteOn,
    output logic        beatTick,
    output logic        running
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  nextState;
    logic [23:0] divider;
    logic [23:0] period;
    logic        lastCycle;
    logic [3:0]  nextBeat;
    logic [15:0] pattern [4];

    function automatic logic [3:0] stepColumn(input logic [15:0] r0, input logic [15:0] r1,
                                              input logic [15:0] r2, input logic [15:0] r3,
                                              input logic [3:0] idx);
        return {r3[idx], r2[idx], r1[idx], r0[idx]};
    endfunction

    // A tempo change can leave the divider beyond the new period; >= makes that step advance at once.
    assign period    = 24'(BASE_TICKS) >> tempoSel;
    assign lastCycle = (divider >= (period - 24'd1));
    assign nextBeat  = beat + 4'd1;

    always_comb begin
        nextState = state;
        if (stop) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (play) nextState = RUN;
                RUN:     if (play) nextState = HOLD;
                HOLD:    if (play) nextState = RUN;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            divider  <= '0;
            beat     <= '0;
            beatTick <= 1'b0;
            noteOn   <= '0;
        end else begin
            state    <= nextState;
            running  <= (nextState == RUN);
            beatTick <= 1'b0;
            noteOn   <= '0;
            if (stop) begin
                beat    <= '0;
                divider <= '0;
            end else if (play && state == IDLE) begin
                beat     <= '0;
                divider  <= '0;
                beatTick <= 1'b1;
                noteOn   <= stepColumn(pattern[0], pattern[1], pattern[2], pattern[3], 4'd0);
            end else if (!play && state == RUN) begin
                if (lastCycle) begin
                    divider  <= '0;
                    beat     <= nextBeat;
                    beatTick <= 1'b1;
                    noteOn   <= stepColumn(pattern[0], pattern[1], pattern[2], pattern[3], nextBeat);
                end else begin
                    divider <= divider + 24'd1;
                end
            end
        end
    end

    // Toggle addresses the cursor row as it stood before any same-cycle cursor move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 4; r++) pattern[r] <= '0;
        end else if (clear) begin
            for (int r = 0; r < 4; r++) pattern[r] <= '0;
        end else if (toggle) begin
            pattern[select][colIn] <= ~pattern[select][colIn];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select <= '0;
        end else if (rowUp && !rowDown) begin
            select <= select + 2'd1;
        end else if (rowDown && !rowUp) begin
            select <= select - 2'd1;
        end
    end

    assign qOut1 = pattern[0];
    assign qOut2 = pattern[1];
    assign qOut3 = pattern[2];
    assign qOut4 = pattern[3];

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus randomized pulses, checked every cycle
// against a step-level behavioural model of the sequencer.
module tb_step_sequencer;

    localparam int BT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0, stop = 1'b0, rowUp = 1'b0, rowDown = 1'b0;
    logic        toggle = 1'b0, clear = 1'b0;
    logic [3:0]  colIn = '0;
    logic [1:0]  tempoSel = '0;
    logic [15:0] qOut1, qOut2, qOut3, qOut4;
    logic [3:0]  beat;
    logic [1:0]  select;
    logic [3:0]  noteOn;
    logic        beatTick;
    logic        running;

    int errors = 0;
    int checks = 0;
    bit cmpEn = 1'b0;

    step_sequencer #(.BASE_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .play(play), .stop(stop), .rowUp(rowUp), .rowDown(rowDown),
        .toggle(toggle), .clear(clear), .colIn(colIn), .tempoSel(tempoSel),
        .qOut1(qOut1), .qOut2(qOut2), .qOut3(qOut3), .qOut4(qOut4), .beat(beat),
        .select(select), .noteOn(noteOn), .beatTick(beatTick), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: 0=idle, 1=run, 2=hold; step counter and cycle-in-step counter.
    int       mMode = 0;
    int       mCount = 0;
    int       mStep = 0;
    int       mRow = 0;
    bit [15:0] mPat [4];
    bit [3:0] mNote = '0;
    bit       mTick = 1'b0;

    function automatic bit [3:0] notesAt(input bit [15:0] p [4], input int s);
        bit [3:0] n;
        for (int r = 0; r < 4; r++) n[r] = p[r][s];
        return n;
    endfunction

    task automatic modelClear();
        mMode = 0; mCount = 0; mStep = 0; mRow = 0; mNote = '0; mTick = 1'b0;
        for (int r = 0; r < 4; r++) mPat[r] = '0;
    endtask

    always @(posedge reset) modelClear();

    always @(posedge clk) begin
        if (reset) begin
            modelClear();
        end else begin
            bit [15:0] old [4];
            int period;
            old = mPat;
            period = BT / (1 << tempoSel);
            mTick = 1'b0;
            mNote = '0;
            if (clear) begin
                for (int r = 0; r < 4; r++) mPat[r] = '0;
            end else if (toggle) begin
                mPat[mRow][colIn] = ~mPat[mRow][colIn];
            end
            if (rowUp && !rowDown) mRow = (mRow + 1) % 4;
            else if (rowDown && !rowUp) mRow = (mRow + 3) % 4;
            if (stop) begin
                mMode = 0; mStep = 0; mCount = 0;
            end else if (play) begin
                if (mMode == 0) begin
                    mMode = 1; mStep = 0; mCount = 0;
                    mTick = 1'b1; mNote = notesAt(old, 0);
                end else begin
                    mMode = (mMode == 1) ? 2 : 1;
                end
            end else if (mMode == 1) begin
                if (mCount + 1 >= period) begin
                    mCount = 0;
                    mStep = (mStep + 1) % 16;
                    mTick = 1'b1;
                    mNote = notesAt(old, mStep);
                end else begin
                    mCount++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            check("beat", 32'(beat), 32'(mStep));
            check("running", 32'(running), 32'(mMode == 1));
            check("beatTick", 32'(beatTick), 32'(mTick));
            check("noteOn", 32'(noteOn), 32'(mNote));
            check("select", 32'(select), 32'(mRow));
            check("patterns", {qOut1 ^ qOut3, qOut2 ^ qOut4}, {mPat[0] ^ mPat[2], mPat[1] ^ mPat[3]});
            check("qOut1", 32'(qOut1), 32'(mPat[0]));
            check("qOut4", 32'(qOut4), 32'(mPat[3]));
        end
    end

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic waitTick(input int limit, output int waited);
        waited = 0;
        for (int k = 1; k <= limit; k++) begin
            nextCycle();
            if (beatTick) begin
                waited = k;
                break;
            end
        end
        if (waited == 0) check("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int gap;
        int heldBeat;
        bit holdOk;
        repeat (2) nextCycle();
        reset = 1'b0;
        cmpEn = 1'b1;
        check("rst_q1", 32'(qOut1), 32'h0);
        check("rst_beat", 32'(beat), 32'h0);
        check("rst_running", 32'(running), 32'h0);

        // Pattern editing with the row cursor
        colIn = 4'd3; toggle = 1'b1; nextCycle();
        toggle = 1'b0; rowUp = 1'b1; nextCycle();
        rowUp = 1'b0; toggle = 1'b1; nextCycle();
        toggle = 1'b0;
        check("edit_q1", 32'(qOut1), 32'h0008);
        check("edit_q2", 32'(qOut2), 32'h0008);
        check("edit_sel", 32'(select), 32'd1);
        clear = 1'b1; nextCycle();
        clear = 1'b0; rowDown = 1'b1; nextCycle();
        rowDown = 1'b0; colIn = 4'd0; toggle = 1'b1; nextCycle();
        toggle = 1'b0;
        check("setup_q1", 32'(qOut1), 32'h0001);

        // Start from idle, step period and wrap
        play = 1'b1; nextCycle();
        play = 1'b0;
        check("start_running", 32'(running), 32'd1);
        check("start_beat", 32'(beat), 32'd0);
        check("start_note", 32'(noteOn), 32'b0001);
        check("start_tick", 32'(beatTick), 32'd1);
        waitTick(20, gap);
        check("period8", 32'(gap), 32'd8);
        for (int k = 0; k < 200; k++) begin
            nextCycle();
            if (beatTick && beat == 4'd0) break;
        end
        check("wrap_beat", 32'(beat), 32'd0);
        check("wrap_note", 32'(noteOn), 32'b0001);
        check("wrap_tick", 32'(beatTick), 32'd1);

        // Faster tempo, pause and resume
        tempoSel = 2'd2;
        waitTick(10, gap);
        waitTick(10, gap);
        check("period2", 32'(gap), 32'd2);
        play = 1'b1; nextCycle();
        play = 1'b0;
        heldBeat = int'(beat);
        holdOk = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nextCycle();
            if (beatTick || noteOn != 0 || running || int'(beat) != heldBeat) holdOk = 1'b0;
        end
        check("hold_frozen", 32'(holdOk), 32'd1);
        play = 1'b1; nextCycle();
        play = 1'b0;
        check("resume_notick", 32'(beatTick), 32'd0);
        waitTick(10, gap);
        check("resume_beat", 32'(beat), 32'((heldBeat + 1) % 16));

        // Same-cycle events
        stop = 1'b1; play = 1'b1; nextCycle();
        stop = 1'b0; play = 1'b0;
        check("stopplay_run", 32'(running), 32'd0);
        check("stopplay_beat", 32'(beat), 32'd0);
        rowUp = 1'b1; rowDown = 1'b1; nextCycle();
        rowUp = 1'b0; rowDown = 1'b0;
        check("updown_sel", 32'(select), 32'd0);
        colIn = 4'd5; toggle = 1'b1; clear = 1'b1; nextCycle();
        toggle = 1'b0; clear = 1'b0;
        check("clrtog_all", 32'(qOut1 | qOut2 | qOut3 | qOut4), 32'h0);
        rowDown = 1'b1; nextCycle();
        rowDown = 1'b0;
        check("down_wrap", 32'(select), 32'd3);

        // Toggle the upcoming step on the edge the step advances
        tempoSel = 2'd0;
        play = 1'b1; nextCycle();
        play = 1'b0;
        repeat (7) nextCycle();
        colIn = 4'd1; toggle = 1'b1; nextCycle();
        toggle = 1'b0;
        check("edge_tick", 32'(beatTick), 32'd1);
        check("edge_beat", 32'(beat), 32'd1);
        check("edge_note_old", 32'(noteOn), 32'd0);
        check("edge_q4_new", 32'(qOut4), 32'h0002);

        // Asynchronous reset mid-run
        repeat (3) nextCycle();
        #2 reset = 1'b1;
        #1;
        check("areset_run", 32'(running), 32'd0);
        check("areset_q4", 32'(qOut4), 32'h0);
        check("areset_sel", 32'(select), 32'd0);
        nextCycle();
        reset = 1'b0;
        repeat (10) nextCycle();
        check("post_reset_idle", 32'(running | beatTick), 32'd0);
        play = 1'b1; nextCycle();
        play = 1'b0;
        check("post_reset_play", 32'(running), 32'd1);

        // Randomized pulse traffic
        for (int k = 0; k < 3000; k++) begin
            play     = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 149) == 0);
            rowUp    = ($urandom_range(0, 9) == 0);
            rowDown  = ($urandom_range(0, 9) == 0);
            toggle   = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 199) == 0);
            colIn    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) tempoSel = 2'($urandom_range(0, 3));
            nextCycle();
        end
        play = 1'b0; stop = 1'b0; rowUp = 1'b0; rowDown = 1'b0; toggle = 1'b0; clear = 1'b0;
        nextCycle();
        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter BASE_TICKS, default 12500000, meaning clk cycles per step at tempoSel=0 (24-bit; minimum 8).
REQ-002 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have ports: play  input  1  one-cycle pulse; start/pause toggle.
REQ-005 SHALL have ports: stop  input  1  one-cycle pulse; stop and rewind to step 0.
REQ-006 SHALL have ports: rowUp, rowDown  input  1 each  one-cycle pulses moving the row cursor.
REQ-007 SHALL have ports: toggle  input  1  one-cycle pulse; invert the pattern bit at (select, colIn).
REQ-008 SHALL have ports: clear  input  1  one-cycle pulse; zero all patterns.
REQ-009 SHALL have ports: colIn  input  4  column cursor used by toggle.
REQ-010 SHALL have ports: tempoSel  input  2  step period = BASE_TICKS >> tempoSel cycles.
REQ-011 SHALL have ports: qOut1, qOut2, qOut3, qOut4  output  16 each  row patterns, bit n = step n.
REQ-012 SHALL have ports: beat  output  4  current step index.
REQ-013 SHALL have ports: select  output  2  current row cursor (row 0 = qOut1).
REQ-014 SHALL have ports: noteOn  output  4  one-cycle pulse per row, bit r = row r fires.
REQ-015 SHALL have ports: beatTick  output  1  one-cycle pulse on every step entry.
REQ-016 SHALL have ports: running  output  1  high in state RUN.

Function
REQ-017 SHALL implement states IDLE, RUN and HOLD.
REQ-018 SHALL take these transitions: IDLE -play-> RUN; RUN -play-> HOLD; HOLD -play-> RUN; any state -stop-> IDLE.
REQ-019 SHALL let stop win over play when both occur in the same cycle.
REQ-020 SHALL, on entering IDLE, set beat=0 and clear the divider.
REQ-021 SHALL preserve beat and the divider in HOLD; RUN resumes the count where it paused.
REQ-022 SHALL count the divider 0..P-1 in RUN only, where P = BASE_TICKS >> tempoSel, sampled each cycle.
REQ-023 SHALL, when the divider equals P-1, advance beat (15 wraps to 0) and reset the divider to 0 at that edge.
REQ-024 SHALL, if a tempoSel change leaves divider >= P-1, advance on the next cycle and reset the divider.
REQ-025 SHALL register beatTick and noteOn so they assert for exactly one cycle, coincident with the new beat value.
REQ-026 SHALL drive noteOn[r] = pattern row r bit [new beat], using pattern contents before any same-edge edit.
REQ-027 SHALL, on IDLE->RUN, pulse beatTick and noteOn for step 0 in the first cycle running=1 (one cycle after play), with the divider starting at 0.
REQ-028 SHALL NOT pulse beatTick or noteOn on HOLD->RUN.
REQ-029 SHALL make select wrap: rowUp increments (3 -> 0), rowDown decrements (0 -> 3).
REQ-030 SHALL leave select unchanged when rowUp and rowDown occur in the same cycle.
REQ-031 SHALL apply toggle using select before any same-cycle cursor move; toggle is allowed in every state.
REQ-032 SHALL zero all four patterns on clear, with clear winning over a same-cycle toggle.
REQ-033 SHALL make every output a register output, with no combinational path from inputs to outputs.

Reset
REQ-034 SHALL, on reset assertion, asynchronously force: state IDLE, divider 0, beat 0, select 0, qOut1..4 = 16'h0000, noteOn 0, beatTick 0, running 0.
REQ-035 SHALL ignore all pulse inputs while reset is high.
REQ-036 SHALL, if reset occurs mid-RUN, lose patterns and position, and require play to restart after release.

Verification (BASE_TICKS=8)
REQ-037 SHALL cover: toggle with colIn=3, select=0, then rowUp and toggle with colIn=3 -> qOut1=16'h0008, qOut2=16'h0008, select=1.
REQ-038 SHALL cover: qOut1=16'h0001, tempoSel=0, play -> next cycle running=1, beat=0, noteOn=4'b0001, beatTick=1; beatTick repeats every 8 cycles; beat=15 -> 0 wraps with noteOn=4'b0001 again.
REQ-039 SHALL cover: tempoSel=2 in RUN -> beatTick every 2 cycles; play -> HOLD, beat frozen for 20 cycles with no pulses; play -> resumes from the same beat and divider.
REQ-040 SHALL cover: same-cycle events: rowUp+rowDown -> select unchanged; clear+toggle -> all qOut=0; stop+play -> IDLE, beat=0; rowDown at select=0 -> 3.
REQ-041 SHALL cover: toggle of the bit at the upcoming beat on the same edge the beat advances -> noteOn reflects the old bit and qOut shows the new bit one cycle later.
REQ-042 SHALL cover: reset asserted asynchronously mid-RUN with patterns set -> outputs go to reset values before the next clk edge and stay idle after release until play.
